// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: emits round keys 0..NR one per valid/ready
// handshake, computing each next key on the fly from the current one.
module key_expansion #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cipherkey,
  input  logic         ready,
  output logic [127:0] roundkey,
  output logic [3:0]   roundnum,
  output logic         valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    FIN
  } state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t       state, state_nx;
  logic [127:0] key_q, key_nx;
  logic [3:0]   num_q, num_nx;
  logic [7:0]   rcon_q, rcon_nx;

  logic [31:0] w0, w1, w2, w3, rot, sub, t;
  logic [31:0] n0, n1, n2, n3;
  logic [7:0]  rcon_xt;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
  assign t   = sub ^ {rcon_q, 24'h000000};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rcon_xt = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      key_q  <= '0;
      num_q  <= '0;
      rcon_q <= 8'h01;
    end else begin
      state  <= state_nx;
      key_q  <= key_nx;
      num_q  <= num_nx;
      rcon_q <= rcon_nx;
    end
  end

  always_comb begin
    state_nx = state;
    key_nx   = key_q;
    num_nx   = num_q;
    rcon_nx  = rcon_q;
    valid    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          key_nx   = cipherkey;
          num_nx   = '0;
          rcon_nx  = 8'h01;
          state_nx = EMIT;
        end
      end
      EMIT: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (ready) begin
          if (num_q == 4'(NR)) begin
            state_nx = FIN;
          end else begin
            key_nx  = {n0, n1, n2, n3};
            num_nx  = num_q + 4'd1;
            rcon_nx = rcon_xt;
          end
        end
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign roundkey = key_q;
  assign roundnum = num_q;

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: a word-oriented AES key-schedule model with an
// S-box derived from GF(2^8) inversion, scoreboarded against the DUT each cycle.
module tb_key_expansion;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] cipherkey;
  logic         ready;
  logic [127:0] roundkey;
  logic [3:0]   roundnum;
  logic         valid;
  logic         busy;
  logic         done;

  key_expansion #(.NR(10)) dut (
    .clk(clk), .rst(rst), .start(start), .cipherkey(cipherkey), .ready(ready),
    .roundkey(roundkey), .roundnum(roundnum), .valid(valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_keys [11];

  bit           mon_en   = 1'b0;
  int           mon_idx  = 11;
  bit           exp_done = 1'b0;
  int           done_cnt = 0;
  bit           prev_stall = 1'b0;
  logic [127:0] prev_key;
  logic [3:0]   prev_num;
  bit           rnd_mode = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      if (a != 0)
        for (int b = 1; b < 256; b++)
          if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 word recurrence over all 44 words, then regrouped into 11 keys.
  task automatic build_schedule(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic pick_ready();
    return rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mon_en) begin
      bit ev;
      ev = (mon_idx <= 10);
      check("valid", valid, ev);
      check("busy", busy, ev);
      check("done", done, exp_done);
      exp_done = 1'b0;
      if (ev) begin
        check("roundnum", roundnum, mon_idx);
        check("roundkey", roundkey, exp_keys[mon_idx]);
        if (prev_stall) begin
          check("stall_key", roundkey, prev_key);
          check("stall_num", roundnum, prev_num);
        end
        prev_stall = !ready;
        prev_key   = roundkey;
        prev_num   = roundnum;
        if (ready) begin
          if (mon_idx == 10) exp_done = 1'b1;
          mon_idx++;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Returns one edge after the start edge, with key 0 on the outputs.
  task automatic begin_sched(input logic [127:0] k);
    build_schedule(k);
    start     = 1'b1;
    cipherkey = k;
    @(posedge clk); #1;
    start      = 1'b0;
    cipherkey  = {$urandom, $urandom, $urandom, $urandom};
    mon_idx    = 0;
    prev_stall = 1'b0;
    exp_done   = 1'b0;
    mon_en     = 1'b1;
    ready      = pick_ready();
  endtask

  // Latency counts clock edges from the start cycle up to the done cycle.
  task automatic run_until_done(input bit poke_start, input int budget, output int latency);
    int  c0;
    bit  seen;
    c0 = done_cnt; seen = 1'b0; latency = 1;
    while (!seen && latency < budget) begin
      @(posedge clk); #1;
      latency++;
      start = 1'b0;
      if (poke_start && ((valid && roundnum == 4'd4) || done)) start = 1'b1;
      ready = pick_ready();
      @(negedge clk); #1;
      if (done_cnt != c0) seen = 1'b1;
    end
    check("done_seen", seen, 1'b1);
  endtask

  task automatic finish_sched();
    @(posedge clk); #1;
    start = 1'b0;
    ready = 1'b1;
  endtask

  initial begin
    int lat;
    int c;
    int dc;
    bit found;

    rst = 1'b1; start = 1'b0; ready = 1'b1; cipherkey = '0;
    build_sbox();
    #1;
    check("rst_roundkey", roundkey, 128'h0);
    check("rst_roundnum", roundnum, 4'd0);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    build_schedule(128'h0);
    check("model_zero_r1", exp_keys[1], 128'h62636363626363636263636362636363);
    check("model_zero_r10", exp_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // A.1 vector, ready held high
    begin_sched(KEY_A1);
    check("model_a1_r1", exp_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("model_a1_r2", exp_keys[2], 128'hf2c295f27a96b9435935807a7359f67f);
    check("model_a1_r10", exp_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_until_done(1'b0, 40, lat);
    check("a1_done_latency", lat, 12);
    finish_sched();

    // Back-to-back restart in the first IDLE cycle, with random backpressure
    rnd_mode = 1'b1;
    begin_sched(KEY_A1);
    run_until_done(1'b0, 200, lat);
    finish_sched();
    rnd_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // start pulses at roundnum 4 and during FIN must be ignored
    begin_sched(KEY_A1);
    dc = done_cnt;
    run_until_done(1'b1, 40, lat);
    check("poke_done_latency", lat, 12);
    finish_sched();
    repeat (4) @(posedge clk);
    #1;
    check("poke_single_done", done_cnt - dc, 1);

    // All-zero key
    begin_sched(128'h0);
    run_until_done(1'b0, 40, lat);
    check("zero_done_latency", lat, 12);
    finish_sched();

    // Mid-schedule reset at roundnum 6
    begin_sched(KEY_A1);
    c = 0; found = 1'b0;
    while (!found && c < 30) begin
      if (valid && roundnum == 4'd6) found = 1'b1;
      else begin
        @(posedge clk); #1;
        c++;
      end
    end
    check("reach_rn6", found, 1'b1);
    mon_en = 1'b0;
    exp_done = 1'b0;
    dc = done_cnt;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_roundnum", roundnum, 4'd0);
    check("mid_rst_roundkey", roundkey, 128'h0);
    check("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("post_rst_valid", valid, 1'b0);
    end
    check("post_rst_no_done", done_cnt - dc, 0);
    @(posedge clk); #1;

    rnd_mode = 1'b1;
    begin_sched(128'h0);
    run_until_done(1'b0, 200, lat);
    finish_sched();
    rnd_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_expansion.md
# key_expansion

Iterative AES-128 key schedule that sits directly upstream of `round`. It takes a 128-bit cipher key and produces the 11 round keys (round 0 to round 10) one per handshake, in order. It drives the `key` input of `round` through a valid/ready handshake, so the round datapath never needs to store the full expanded schedule.

## Interface
- `NR`, default 10: number of rounds; keys 0..`NR` are emitted (only 10 is supported).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a new schedule; sampled only in IDLE.
- `cipherkey`  in  128  AES key, FIPS-197 byte order (byte 0 = [127:120]); sampled on the accepted `start`.
- `ready`  in  1  downstream (round) accepts `roundkey` this cycle.
- `roundkey`  out  128  current round key, FIPS-197 byte order; column c = [127-32c -: 32].
- `roundnum`  out  4  index of `roundkey`, 0..10.
- `valid`  out  1  `roundkey`/`roundnum` are meaningful.
- `busy`  out  1  a schedule is in progress (EMIT state).
- `done`  out  1  one-cycle pulse after key 10 is accepted.

## Operation
- States: IDLE, EMIT, FIN.
- IDLE: `valid`=0, `busy`=0. `start`=1 → load `cipherkey` into the key register, `roundnum`←0, rcon←8'h01, go to EMIT.
- EMIT: `valid`=1, `busy`=1; `roundkey` = key register, `roundnum` held.
  - `valid`&`ready`, `roundnum`<10 → key register ← next key, `roundnum`+1, rcon ← xtime(rcon).
  - `valid`&`ready`, `roundnum`=10 → go to FIN.
  - `ready`=0 → hold all outputs stable (no change while stalled).
- FIN: `valid`=0, `busy`=0, `done`=1 for exactly one cycle, then go to IDLE.
- Next-key computation (w0..w3 = columns of current key):
  - t = SubWord(RotWord(w3)) ^ {rcon,8'h00,8'h00,8'h00}
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - RotWord {a,b,c,d} → {b,c,d,a}; SubWord applies the FIPS-197 forward S-box to each byte (4 S-box instances, combinational).
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36. xtime = shift left by 1, XOR 8'h1b if bit 7 was set; 8 bits wide, no carry kept.
- `start` in EMIT or FIN is ignored; there is no queueing. `cipherkey` changing after the accepted `start` has no effect.
- `rst` asserted at any time, including mid-schedule: go immediately to IDLE and clear all registers. No `done` pulse is generated.

## Timing
- Reset values: `roundkey`=128'h0, `roundnum`=0, `valid`=0, `busy`=0, `done`=0, rcon=8'h01.
- `start` sampled high at edge t → `valid`=1 with key 0 (= `cipherkey`) after edge t (zero-wait first key).
- One key advances per edge where `valid`&`ready`. With `ready` tied high, keys 0..10 appear on 11 consecutive cycles.
- `done` is high in the cycle after the edge that accepted key 10; `valid` is 0 in that cycle.
- Earliest next `start` is accepted in the cycle after the `done` pulse, i.e. in IDLE.
- Outputs are registered, except `valid`, `busy` and `done`, which decode the registered state. There is no combinational path from `ready` to any output.
- Critical path: S-box, XOR chain w0'→w3', into the key register.

## Test plan
- FIPS-197 A.1 vector: `cipherkey`=2b7e151628aed2a6abf7158809cf4f3c, `ready`=1 → roundnum 0 = the same value; 1 = a0fafe1788542cb123a339392a6c7605; 2 = f2c295f27a96b9435935807a7359f67f; 10 = d014f9a8c9ee2589e13f0cc8b6630ca6. `done` pulses 12 cycles after `start`.
- All-zero key, `ready`=1 → round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: A.1 key with `ready` toggling pseudo-randomly → same 11 keys in order, none skipped or repeated. `roundkey` and `roundnum` are stable while `valid`&!`ready`.
- `start` pulsed at roundnum 4 and again during FIN → ignored; the schedule completes unchanged with a single `done`.
- `rst` asserted at roundnum 6, held low otherwise → next cycle `valid`=0, `roundnum`=0, `roundkey`=0, no `done`. A subsequent `start` with the zero key reproduces the zero-key vectors.
- Back-to-back: `start` in the first IDLE cycle after `done` with the A.1 key → key 0 is valid on the next cycle and all 11 keys are correct.
